// File: rtl/spi_flash_fetch_if.sv
// Request/response port of the SPI flash fetch block: valid/ready request in,
// one-cycle valid pulse with the fetched word out.
interface spi_flash_fetch_if #(
    parameter int ADDR_W = 24
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rd_valid;
    logic [31:0]       rd_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/spi_flash_fetch.sv
// Single-lane SPI (mode 0, MSB first) flash read master: one 32-bit little-endian word per request.
// Build macro FAST_READ_EN selects command 0x0B with 8 dummy SPI clocks before the data phase.
module spi_flash_fetch #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 24
) (
    input  logic             clock,
    input  logic             resetb,
    spi_flash_fetch_if.slave bus,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic             flash_io0,
    input  logic             flash_io1
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = 8;
    localparam int TX_W  = 8 + ADDR_W;
`ifdef FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_GAP} state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic              phase_reg, phase_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [TX_W-1:0]   tx_reg, tx_next;
    logic [31:0]       rx_reg, rx_next;
    logic [31:0]       rd_data_reg, rd_data_next;
    logic [31:0]       rx_swapped;
    logic              timer_run, half_end, bit_end, last_bit;

    // First byte shifted in lands in the top of rx_reg but belongs in the bottom of rd_data.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_swap
        assign rx_swapped[8*gi +: 8] = rx_reg[8*(3-gi) +: 8];
    end

    // The GAP reuses the bit timer: one silent SPI bit period is exactly the required idle time.
    assign timer_run = (state_reg inside {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP});
    assign half_end  = timer_run && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign bit_end   = half_end && phase_reg;
    assign last_bit  = (bit_cnt_reg == '0);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= S_IDLE;
            div_cnt_reg <= '0;
            phase_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            phase_reg   <= phase_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            rd_data_reg <= rd_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        phase_next   = phase_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        rd_data_next = rd_data_reg;

        if (timer_run) begin
            if (half_end) begin
                div_cnt_next = '0;
                phase_next   = ~phase_reg;
                if (!phase_reg && state_reg == S_DATA)
                    rx_next = {rx_reg[30:0], flash_io1};
            end else begin
                div_cnt_next = div_cnt_reg + 1'b1;
            end
        end

        if (bit_end) begin
            tx_next      = {tx_reg[TX_W-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_next   = S_CMD;
                    tx_next      = {READ_CMD, bus.req_addr};
                    bit_cnt_next = CNT_W'(7);
                    div_cnt_next = '0;
                    phase_next   = 1'b0;
                end
            end
            S_CMD: begin
                if (bit_end && last_bit) begin
                    state_next   = S_ADDR;
                    bit_cnt_next = CNT_W'(ADDR_W - 1);
                end
            end
            S_ADDR: begin
                if (bit_end && last_bit) begin
`ifdef FAST_READ_EN
                    state_next   = S_DUMMY;
                    bit_cnt_next = CNT_W'(7);
`else
                    state_next   = S_DATA;
                    bit_cnt_next = CNT_W'(31);
`endif
                end
            end
            S_DUMMY: begin
                if (bit_end && last_bit) begin
                    state_next   = S_DATA;
                    bit_cnt_next = CNT_W'(31);
                end
            end
            S_DATA: begin
                if (bit_end && last_bit) begin
                    state_next   = S_DONE;
                    rd_data_next = rx_swapped;
                end
            end
            S_DONE:  state_next = S_GAP;
            S_GAP:   if (bit_end) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        flash_csb     = 1'b1;
        flash_clk     = 1'b0;
        flash_io0     = 1'b0;
        bus.req_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = rd_data_reg;
        case (state_reg)
            S_IDLE: bus.req_ready = 1'b1;
            S_CMD, S_ADDR: begin
                flash_csb = 1'b0;
                flash_clk = phase_reg;
                flash_io0 = tx_reg[TX_W-1];
            end
            S_DUMMY, S_DATA: begin
                flash_csb = 1'b0;
                flash_clk = phase_reg;
            end
            S_DONE:  bus.rd_valid = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_spi_flash_fetch.sv
// Bench for spi_flash_fetch: behavioural serial-flash model plus a request scoreboard.
// Define FAST_READ_EN for both bench and RTL to exercise the fast-read build.
module tb_spi_flash_fetch;
    parameter int CLK_DIV = 2;
`ifdef FAST_READ_EN
    localparam int         NB      = 72;
    localparam int         HDR     = 40;
    localparam logic [7:0] CMD_EXP = 8'h0B;
`else
    localparam int         NB      = 64;
    localparam int         HDR     = 32;
    localparam logic [7:0] CMD_EXP = 8'h03;
`endif
    localparam int LAT = NB * 2 * CLK_DIV + 1;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    logic flash_csb, flash_clk, flash_io0;
    logic flash_io1 = 1'b0;

    spi_flash_fetch_if #(.ADDR_W(24)) bus ();

    spi_flash_fetch #(.CLK_DIV(CLK_DIV), .ADDR_W(24)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .bus       (bus.slave),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1)
    );

    initial forever #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash contents: explicit bytes where written, otherwise a fixed hash of the address.
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
    endfunction

    // ---------------- serial flash model ----------------
    int          fl_edges = 0;
    logic [39:0] fl_hdr   = '0;
    logic [7:0]  fl_cmd   = '0;
    logic [23:0] fl_addr  = '0;
    logic [7:0]  last_cmd = '0;
    logic [23:0] last_addr = '0;
    logic [23:0] addr_q[$];

    initial forever begin
        @(negedge flash_csb);
        fl_edges  = 0;
        fl_hdr    = '0;
        flash_io1 = 1'b0;
    end

    initial forever begin
        @(posedge flash_clk);
        if (flash_csb === 1'b0) begin
            if (fl_edges < HDR) fl_hdr = {fl_hdr[38:0], flash_io0};
            fl_edges++;
            if (fl_edges == 8)  fl_cmd  = fl_hdr[7:0];
            if (fl_edges == 32) fl_addr = fl_hdr[23:0];
        end
    end

    // Mode 0: the flash shifts its next bit out on the falling edge of flash_clk.
    initial forever begin
        int d;
        logic [7:0] bt;
        @(negedge flash_clk);
        if (flash_csb === 1'b0 && fl_edges >= HDR && fl_edges < HDR + 32) begin
            d  = fl_edges - HDR;
            bt = flash_byte(fl_addr + 24'(d / 8));
            flash_io1 = bt[7 - (d % 8)];
        end
    end

    initial forever begin
        @(posedge flash_csb);
        if (resetb === 1'b1) begin
            last_cmd  = fl_cmd;
            last_addr = fl_addr;
            check_eq("spi_cmd", fl_cmd, CMD_EXP);
            check_eq("spi_clocks", fl_edges, NB);
            check_eq("spi_pending", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) check_eq("spi_addr", fl_addr, addr_q.pop_front());
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] word; int cyc; } exp_t;
    exp_t        exp_q[$];
    int          cyc = 0;
    int          busy_till = 0;
    int          acc_count = 0, acc_cyc = 0;
    int          rv_count = 0, rv_cyc = 0;
    int          idle_viol = 0;
    logic [31:0] last_data = '0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clock);
        if (flash_csb === 1'b1 && flash_clk !== 1'b0) idle_viol++;
        if (resetb !== 1'b1) begin
            exp_q.delete();
            addr_q.delete();
            busy_till = 0;
        end else begin
            if (bus.req_valid) check_eq("req_ready", bus.req_ready, cyc >= busy_till);
            if (bus.rd_valid) begin
                rv_count++;
                rv_cyc    = cyc;
                last_data = bus.rd_data;
                check_eq("rd_valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rd_data", bus.rd_data, e.word);
                    check_eq("latency", cyc - e.cyc, LAT);
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_count++;
                acc_cyc = cyc;
                e.word  = exp_word(bus.req_addr);
                e.cyc   = cyc;
                exp_q.push_back(e);
                addr_q.push_back(bus.req_addr);
                busy_till = cyc + (NB + 1) * 2 * CLK_DIV + 2;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_req(input logic [23:0] a);
        int n;
        int acc0;
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        acc0 = acc_count;
        n = 0;
        while (acc_count == acc0 && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("accept_in_time", n < 2000, 1);
        bus.req_valid = 1'b0;
        bus.req_addr  = 24'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clock);
            n++;
        end
        check_eq("done_in_time", n < 1000, 1);
        repeat (2 * CLK_DIV + 2) @(posedge clock);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded 600000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int rv0;
        int n;
        logic [23:0] a;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_csb",      flash_csb,     1);
        check_eq("rst_clk",      flash_clk,     0);
        check_eq("rst_io0",      flash_io0,     0);
        check_eq("rst_rd_valid", bus.rd_valid,  0);
        check_eq("rst_rd_data",  bus.rd_data,   0);
        check_eq("rst_req_ready", bus.req_ready, 1);
        @(posedge clock); #1;
        resetb = 1'b1;

        // Basic fetch
        mem[24'h000000] = 8'h6F; mem[24'h000001] = 8'h00;
        mem[24'h000002] = 8'h00; mem[24'h000003] = 8'h0B;
        rv0 = rv_count;
        send_req(24'h000000);
        wait_idle();
        check_eq("basic_data", last_data, 32'h0B00006F);
        check_eq("basic_pulses", rv_count - rv0, 1);

        // Bus protocol decode
        send_req(24'h123456);
        wait_idle();
        check_eq("proto_cmd", last_cmd, CMD_EXP);
        check_eq("proto_addr", last_addr, 24'h123456);

        // Back-to-back with req_valid held high
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 24'h000010;
        a0 = acc_count;
        n = 0;
        while (acc_count == a0 && n < 2000) begin @(posedge clock); #1; n++; end
        bus.req_addr = 24'h000014;
        while (acc_count == a0 + 1 && n < 4000) begin @(posedge clock); #1; n++; end
        check_eq("b2b_in_time", n < 4000, 1);
        check_eq("b2b_gap", acc_cyc - rv_cyc, 2 * CLK_DIV + 1);
        bus.req_valid = 1'b0;
        wait_idle();

        // Requests pulsed while busy must be ignored
        a0 = acc_count;
        send_req(24'h000040);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(5, 30)) @(posedge clock);
            #1;
            bus.req_valid = 1'b1;
            bus.req_addr  = 24'($urandom);
            @(posedge clock); #1;
            bus.req_valid = 1'b0;
        end
        wait_idle();
        check_eq("busy_ignored", acc_count - a0, 1);

        // Reset during the address phase
        mem[24'h000004] = 8'h11; mem[24'h000005] = 8'h22;
        mem[24'h000006] = 8'h33; mem[24'h000007] = 8'h44;
        rv0 = rv_count;
        send_req(24'h000200);
        repeat (8 * 2 * CLK_DIV + 6) @(posedge clock);
        #3;
        resetb = 1'b0;
        #1;
        check_eq("abort_csb",       flash_csb,     1);
        check_eq("abort_clk",       flash_clk,     0);
        check_eq("abort_io0",       flash_io0,     0);
        check_eq("abort_req_ready", bus.req_ready, 1);
        check_eq("abort_rd_valid",  bus.rd_valid,  0);
        check_eq("abort_rd_data",   bus.rd_data,   0);
        repeat (2) @(posedge clock);
        #1;
        resetb = 1'b1;
        send_req(24'h000004);
        wait_idle();
        check_eq("post_reset_data", last_data, 32'h44332211);
        check_eq("post_reset_pulses", rv_count - rv0, 1);

        // Address wrap is left to the flash
        mem[24'hFFFFFE] = 8'hAA; mem[24'hFFFFFF] = 8'hBB;
        mem[24'h000000] = 8'hCC; mem[24'h000001] = 8'hDD;
        send_req(24'hFFFFFE);
        wait_idle();
        check_eq("wrap_data", last_data, 32'hDDCCBBAA);

        // Randomized traffic, sometimes back-to-back
        for (int i = 0; i < 16; i++) begin
            a = 24'($urandom);
            if (i % 4 == 0) a = 24'hFFFFFC + 24'($urandom_range(0, 3));
            send_req(a);
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 4)) @(posedge clock);
        end
        wait_idle();

        #1;
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("idle_clk_low", idle_viol, 0);
        check_eq("rd_data_hold", bus.rd_data, last_data);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
